mantissa_normalizer: RTL and testbench
======================================

MANTISSA_NORMALIZER -- requirements
Module: mantissa_normalizer

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width in bits (unsigned, biased).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1: input handshake; transfer when both high on a clock edge.
REQ-005 SHALL have ports in_mant input 16 (raw mantissa, bit 16 MSB), in_exp input EXP_W, and in_carry input 1 (adder carry-out above bit 16).
REQ-006 SHALL have ports sh_A output 16, sh_Shift output 4 and sh_ShiftChoice output 1 (1 = left, 0 = right), driving the external combinational universal barrel shifter.
REQ-007 SHALL have port sh_out input 16, the shifter result, consumed in the same cycle it is driven.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1: output handshake.
REQ-009 SHALL have ports out_mant output 16, out_exp output EXP_W, out_zero output 1, out_denorm output 1 and out_overflow output 1.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT and DONE; in_ready = 1 only in IDLE.
REQ-011 IDLE: on in_valid && in_ready, SHALL register in_mant, in_exp and in_carry, compute the leading-zero count lzc (0..15) of in_mant, and go to SHIFT.
REQ-012 SHIFT (exactly one cycle): SHALL drive sh_A = registered mantissa, sh_Shift and sh_ShiftChoice per REQ-013 to REQ-016, register sh_out into the result, and go to DONE.
REQ-013 Carry set: SHALL use Shift = 1, Choice = 0; out_mant = sh_out OR 0x8000; out_exp = exp + 1.
REQ-014 Carry set and (exp + 1) >= 2^EXP_W - 1: SHALL set out_overflow = 1, out_mant = 0, out_exp = 2^EXP_W - 1.
REQ-015 Carry clear, nonzero mantissa: SHALL use s = min(lzc, exp - 1) when exp >= 1, else s = 0; Shift = s, Choice = 1; out_mant = sh_out; out_exp = exp - s.
REQ-016 Carry clear, zero mantissa: SHALL use Shift = 0, Choice = 1; out_mant = 0, out_exp = 0, out_zero = 1.
REQ-017 SHALL set out_denorm = 1 when out_mant is nonzero and out_mant bit 16 = 0 with carry clear; otherwise out_denorm = 0.
REQ-018 Flags SHALL be mutually exclusive: at most one of out_zero, out_denorm and out_overflow is high.
REQ-019 DONE: SHALL hold out_valid = 1 with all result outputs stable until out_ready = 1, then return to IDLE on that edge.
REQ-020 Latency: out_valid SHALL rise exactly 2 cycles after the accept edge; throughput SHALL be one operation per 3 cycles when out_ready = 1.
REQ-021 In IDLE and DONE, sh_A, sh_Shift and sh_ShiftChoice SHALL be 0.
REQ-022 Outside DONE, out_valid SHALL be 0; result outputs SHALL keep their last values.
REQ-023 in_* values SHALL be ignored while in_ready = 0.

Reset
REQ-024 While reset = 1 on a clock edge, SHALL enter IDLE and clear out_valid, out_mant, out_exp and all flags to 0; in_ready = 1 on the following cycle.
REQ-025 Reset asserted in SHIFT or DONE SHALL discard the operation; no out_valid is produced for it.
REQ-026 reset SHALL take priority over a simultaneous in_valid or out_ready.

Verification
REQ-027 in_mant = 0x0010, exp = 20, carry = 0 -> Shift = 11, Choice = 1 in SHIFT; out_mant = 0x8000, out_exp = 9, flags = 0, out_valid 2 cycles after accept.
REQ-028 in_mant = 0x0001, exp = 5, carry = 0 -> Shift = 4; out_mant = 0x0010, out_exp = 1, out_denorm = 1.
REQ-029 in_mant = 0x8001, exp = 10, carry = 1 -> Shift = 1, Choice = 0; out_mant = 0xC000, out_exp = 11.
REQ-030 carry = 1, exp = 254 -> out_overflow = 1, out_mant = 0, out_exp = 255.
REQ-031 in_mant = 0, exp = 30 -> Shift = 0; out_zero = 1, out_mant = 0, out_exp = 0.
REQ-032 Backpressure and reset checks:
- out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready = 0 throughout.
- reset pulsed during SHIFT -> out_valid = 0 next cycle, in_ready = 1.

Source files
------------

// File: rtl/mantissa_normalizer.sv
// Post-add mantissa normalizer: captures a raw sum, steers an external barrel
// shifter for one cycle, then holds the normalized result until it is taken.
module mantissa_normalizer #(
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_mant,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_carry,
    output logic [15:0]      sh_A,
    output logic [3:0]       sh_Shift,
    output logic             sh_ShiftChoice,
    input  logic [15:0]      sh_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_denorm,
    output logic             out_overflow,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready and holds until the transfer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [15:0]      mant_q;
    logic [EXP_W-1:0] exp_q;
    logic             carry_q;
    logic [3:0]       lzc_q;

    logic [15:0]      res_mant_q, res_mant_d;
    logic [EXP_W-1:0] res_exp_q, res_exp_d;
    logic             zero_q, zero_d;
    logic             denorm_q, denorm_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       lzc_in;
    logic             lzc_found;
    logic [EXP_W:0]   exp_m1;
    logic [EXP_W:0]   exp_p1;
    logic [EXP_W:0]   lzc_ext;
    logic [3:0]       left_amt;
    logic             carry_ovf;

    always_comb begin
        lzc_in    = 4'd15;
        lzc_found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!lzc_found && in_mant[i]) begin
                lzc_in    = 4'(15 - i);
                lzc_found = 1'b1;
            end
        end
    end

    // Left shift is capped so the exponent never drops below 1 (stops at denormal).
    always_comb begin
        exp_m1    = {1'b0, exp_q} - 1'b1;
        exp_p1    = {1'b0, exp_q} + 1'b1;
        lzc_ext   = (EXP_W + 1)'(lzc_q);
        carry_ovf = (exp_p1 >= {1'b0, {EXP_W{1'b1}}});
        if (exp_q == '0) begin
            left_amt = 4'd0;
        end else if (lzc_ext <= exp_m1) begin
            left_amt = lzc_q;
        end else begin
            left_amt = 4'(exp_m1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mant_q     <= '0;
            exp_q      <= '0;
            carry_q    <= 1'b0;
            lzc_q      <= '0;
            res_mant_q <= '0;
            res_exp_q  <= '0;
            zero_q     <= 1'b0;
            denorm_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            res_mant_q <= res_mant_d;
            res_exp_q  <= res_exp_d;
            zero_q     <= zero_d;
            denorm_q   <= denorm_d;
            ovf_q      <= ovf_d;
            if (state_q == IDLE && in_valid) begin
                mant_q  <= in_mant;
                exp_q   <= in_exp;
                carry_q <= in_carry;
                lzc_q   <= lzc_in;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        sh_A           = '0;
        sh_Shift       = '0;
        sh_ShiftChoice = 1'b0;
        res_mant_d     = res_mant_q;
        res_exp_d      = res_exp_q;
        zero_d         = zero_q;
        denorm_d       = denorm_q;
        ovf_d          = ovf_q;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                sh_A     = mant_q;
                zero_d   = 1'b0;
                denorm_d = 1'b0;
                ovf_d    = 1'b0;
                if (carry_q) begin
                    sh_Shift       = 4'd1;
                    sh_ShiftChoice = 1'b0;
                    if (carry_ovf) begin
                        res_mant_d = '0;
                        res_exp_d  = '1;
                        ovf_d      = 1'b1;
                    end else begin
                        res_mant_d = sh_out | 16'h8000;
                        res_exp_d  = exp_q + 1'b1;
                    end
                end else if (mant_q == '0) begin
                    sh_ShiftChoice = 1'b1;
                    res_mant_d     = '0;
                    res_exp_d      = '0;
                    zero_d         = 1'b1;
                end else begin
                    sh_Shift       = left_amt;
                    sh_ShiftChoice = 1'b1;
                    res_mant_d     = sh_out;
                    res_exp_d      = exp_q - EXP_W'(left_amt);
                    denorm_d       = (sh_out != '0) && !sh_out[15];
                end
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_mant     = res_mant_q;
    assign out_exp      = res_exp_q;
    assign out_zero     = zero_q;
    assign out_denorm   = denorm_q;
    assign out_overflow = ovf_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Bench for mantissa_normalizer: directed corner cases, backpressure, reset
// abort and random operations checked against an arithmetic reference model.
module tb_mantissa_normalizer;

    localparam int EXP_W = 8;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_mant;
    logic [EXP_W-1:0] in_exp;
    logic             in_carry;
    logic [15:0]      sh_A;
    logic [3:0]       sh_Shift;
    logic             sh_ShiftChoice;
    logic [15:0]      sh_out;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_mant;
    logic [EXP_W-1:0] out_exp;
    logic             out_zero;
    logic             out_denorm;
    logic             out_overflow;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    mantissa_normalizer #(.EXP_W(EXP_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .in_carry(in_carry),
        .sh_A(sh_A), .sh_Shift(sh_Shift), .sh_ShiftChoice(sh_ShiftChoice),
        .sh_out(sh_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp),
        .out_zero(out_zero), .out_denorm(out_denorm), .out_overflow(out_overflow),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // External universal barrel shifter: 1 = logical left, 0 = logical right.
    assign sh_out = sh_ShiftChoice ? (sh_A << sh_Shift) : (sh_A >> sh_Shift);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Normalization rules written with plain integer arithmetic.
    function automatic void model(input int m, input int e, input int c,
                                  output int x_mant, output int x_exp, output int x_sh,
                                  output int x_ch, output int x_flags);
        int msb, lz, s;
        x_flags = 0;
        if (c != 0) begin
            x_sh = 1; x_ch = 0;
            if (e + 1 >= EXP_MAX) begin
                x_mant = 0; x_exp = EXP_MAX; x_flags = 3'b001;
            end else begin
                x_mant = (m / 2) + 32768; x_exp = e + 1;
            end
        end else if (m == 0) begin
            x_sh = 0; x_ch = 1; x_mant = 0; x_exp = 0; x_flags = 3'b100;
        end else begin
            msb = 0;
            while ((m >> msb) > 1) msb++;
            lz = 15 - msb;
            s = (e >= 1) ? ((lz < e - 1) ? lz : e - 1) : 0;
            x_sh = s; x_ch = 1;
            x_mant = (m * (1 << s)) % 65536;
            x_exp = e - s;
            if (x_mant != 0 && x_mant < 32768) x_flags = 3'b010;
        end
    endfunction

    // Runs one operation starting in IDLE, #1 after an edge; hold = cycles of
    // out_ready low in DONE. Returns #1 after the edge that leaves DONE.
    task automatic do_op(input string tag, input int m, input int e, input int c, input int hold);
        int x_mant, x_exp, x_sh, x_ch, x_flags;
        model(m, e, c, x_mant, x_exp, x_sh, x_ch, x_flags);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_mant   = 16'(m);
        in_exp    = EXP_W'(e);
        in_carry  = 1'(c);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mant  = 16'($urandom);
        chk({tag, ".sh_A"}, 32'(sh_A), 32'(m));
        chk({tag, ".sh_Shift"}, 32'(sh_Shift), 32'(x_sh));
        chk({tag, ".sh_Choice"}, 32'(sh_ShiftChoice), 32'(x_ch));
        chk({tag, ".valid_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".out_mant"}, 32'(out_mant), 32'(x_mant));
        chk({tag, ".out_exp"}, 32'(out_exp), 32'(x_exp));
        chk({tag, ".flags"}, 32'({out_zero, out_denorm, out_overflow}), 32'(x_flags));
        chk({tag, ".sh_idle"}, 32'({sh_A, sh_Shift, sh_ShiftChoice}), 32'd0);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_mant  = 16'($urandom);
            in_exp   = EXP_W'($urandom);
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
            chk({tag, ".hold_mant"}, 32'(out_mant), 32'(x_mant));
            chk({tag, ".hold_exp"}, 32'(out_exp), 32'(x_exp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".keep_mant"}, 32'(out_mant), 32'(x_mant));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_carry = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.outputs", 32'({out_mant, out_exp, out_zero, out_denorm, out_overflow}), 32'd0);
        chk("rst.sh", 32'({sh_A, sh_Shift, sh_ShiftChoice}), 32'd0);

        do_op("lz11", 16'h0010, 20, 0, 0);
        do_op("denorm_cap", 16'h0001, 5, 0, 0);
        do_op("carry", 16'h8001, 10, 1, 0);
        do_op("ovf", 16'hF00F, 254, 1, 0);
        do_op("no_ovf_253", 16'h1234, 253, 1, 0);
        do_op("zero", 16'h0000, 30, 0, 0);
        do_op("exp0", 16'h0100, 0, 0, 0);
        do_op("exp1", 16'h0100, 1, 0, 0);
        do_op("norm_in", 16'h8000, 7, 0, 0);
        do_op("carry_zero", 16'h0000, 3, 1, 0);
        do_op("backpressure", 16'h0ABC, 100, 0, 5);

        // Abort an operation while it is in SHIFT.
        in_valid = 1'b1; in_mant = 16'h0F00; in_exp = 8'd50; in_carry = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        chk("abort.cleared", 32'({out_mant, out_exp}), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort.no_valid", 32'(out_valid), 32'd0);
        end

        for (int n = 0; n < 60; n++) begin
            int m, e, c;
            m = int'($urandom_range(0, 65535)) >> $urandom_range(0, 16);
            e = $urandom_range(0, EXP_MAX);
            c = ($urandom_range(0, 3) == 0) ? 1 : 0;
            do_op("rand", m, e, c, (n % 7 == 3) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
